ctrl_fsm_p: RTL and testbench



---
 rtl/ctrl_fsm_p.sv | 250 +++++++++++++++++++++++++
 tb/tb_ctrl_fsm_p.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm_p.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm_p
// Purpose  : Multi-cycle microcode control unit: FETCH/DECODE/EXEC/MEM sequencer
//            with memory handshake timeout, HALT and illegal-opcode flagging.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm_p #(
    parameter int OP_W         = 3,
    parameter int FETCH_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic [5:0]      inst_en,
    output logic [1:0]      mux_sum,
    output logic            mux_y,
    output logic            we,
    output logic            r,
    output logic            en_fetch,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic            timeout_err
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] c_FETCH_LAST = 3'(FETCH_CYCLES - 1);
    localparam logic [7:0] c_WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

    localparam logic [2:0] c_OP_ADD   = 3'b001;
    localparam logic [2:0] c_OP_SUB   = 3'b010;
    localparam logic [2:0] c_OP_AND   = 3'b011;
    localparam logic [2:0] c_OP_LOAD  = 3'b100;
    localparam logic [2:0] c_OP_STORE = 3'b101;
    localparam logic [2:0] c_OP_PASSX = 3'b110;
    localparam logic [2:0] c_OP_HALT  = 3'b111;

    // Register enables {PC_EN, INST_EN, ADDR_EN, Y_EN, OP_EN, X_EN}
    localparam logic [5:0] c_IE_F0     = 6'b110000;
    localparam logic [5:0] c_IE_F1     = 6'b100001;
    localparam logic [5:0] c_IE_F2     = 6'b100100;
    localparam logic [5:0] c_IE_FN     = 6'b101000;
    localparam logic [5:0] c_IE_DECODE = 6'b000010;
    localparam logic [5:0] c_IE_Y      = 6'b000100;

    state_t          state_q, state_d;
    logic [2:0]      fcnt_q, fcnt_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;

    logic [5:0]      inst_en_d;
    logic [1:0]      mux_sum_d;
    logic            mux_y_d;
    logic            we_d;
    logic            r_d;
    logic            en_fetch_d;
    logic            busy_d;
    logic            halted_d;

    logic            w_bad_q;
    logic            w_bad_d;

    // Any set bit above the 3 decoded bits makes the opcode illegal
    if (OP_W > 3) begin : g_hi_bits
        assign w_bad_q = |op_q[OP_W-1:3];
        assign w_bad_d = |op_d[OP_W-1:3];
    end else begin : g_no_hi_bits
        assign w_bad_q = 1'b0;
        assign w_bad_d = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        wcnt_d    = wcnt_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
                fcnt_d  = 3'd0;
            end
            S_FETCH: begin
                if (fcnt_q == c_FETCH_LAST) begin
                    state_d = S_DECODE;
                end else begin
                    fcnt_d = fcnt_q + 3'd1;
                end
            end
            S_DECODE: begin
                op_d    = op;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                fcnt_d  = 3'd0;
                if (w_bad_q) begin
                    illegal_d = 1'b1;
                end else if (op_q[2:0] == c_OP_LOAD || op_q[2:0] == c_OP_STORE) begin
                    state_d = S_MEM;
                    wcnt_d  = 8'd0;
                end else if (op_q[2:0] == c_OP_HALT) begin
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                // A ready arriving on the final wait cycle still completes cleanly
                if (mem_ready) begin
                    state_d = S_FETCH;
                    fcnt_d  = 3'd0;
                end else if (wcnt_q == c_WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    always_comb begin
        inst_en_d  = 6'b000000;
        mux_sum_d  = 2'b00;
        mux_y_d    = 1'b0;
        we_d       = 1'b0;
        r_d        = 1'b0;
        en_fetch_d = 1'b0;
        busy_d     = 1'b0;
        halted_d   = 1'b0;
        case (state_d)
            S_FETCH: begin
                en_fetch_d = 1'b1;
                busy_d     = 1'b1;
                case (fcnt_d)
                    3'd0:    inst_en_d = c_IE_F0;
                    3'd1:    inst_en_d = c_IE_F1;
                    3'd2:    inst_en_d = c_IE_F2;
                    default: inst_en_d = c_IE_FN;
                endcase
            end
            S_DECODE: begin
                busy_d    = 1'b1;
                inst_en_d = c_IE_DECODE;
            end
            S_EXEC: begin
                busy_d = 1'b1;
                if (!w_bad_d) begin
                    case (op_d[2:0])
                        c_OP_ADD: begin
                            mux_sum_d = 2'b00;
                            mux_y_d   = 1'b1;
                            inst_en_d = c_IE_Y;
                        end
                        c_OP_SUB: begin
                            mux_sum_d = 2'b01;
                            mux_y_d   = 1'b1;
                            inst_en_d = c_IE_Y;
                        end
                        c_OP_AND: begin
                            mux_sum_d = 2'b10;
                            mux_y_d   = 1'b1;
                            inst_en_d = c_IE_Y;
                        end
                        c_OP_PASSX: begin
                            mux_sum_d = 2'b11;
                            mux_y_d   = 1'b1;
                            inst_en_d = c_IE_Y;
                        end
                        c_OP_LOAD:  r_d  = 1'b1;
                        c_OP_STORE: we_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                busy_d = 1'b1;
                if (op_d[2:0] == c_OP_LOAD) begin
                    r_d       = 1'b1;
                    inst_en_d = c_IE_Y;
                end else begin
                    we_d = 1'b1;
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_INIT;
            fcnt_q    <= 3'd0;
            wcnt_q    <= 8'd0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            inst_en   <= 6'b000000;
            mux_sum   <= 2'b00;
            mux_y     <= 1'b0;
            we        <= 1'b0;
            r         <= 1'b0;
            en_fetch  <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            wcnt_q    <= wcnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            inst_en   <= inst_en_d;
            mux_sum   <= mux_sum_d;
            mux_y     <= mux_y_d;
            we        <= we_d;
            r         <= r_d;
            en_fetch  <= en_fetch_d;
            busy      <= busy_d;
            halted    <= halted_d;
        end
    end

    assign illegal     = illegal_q;
    assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_fsm_p
// Purpose  : Directed bench for ctrl_fsm_p across three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm_p;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       cur_clr = 1'b1;
    logic [3:0] cur_op  = 4'd0;
    logic       cur_rdy = 1'b0;
    int         sel     = 0;

    int         fc   = 3;
    int         to   = 15;
    int         opw  = 4;
    logic       m_ill = 1'b0;
    logic       m_to  = 1'b0;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [15:0] expq[$];
    logic [15:0] exp_now;

    logic clr_a, clr_b, clr_c;
    assign clr_a = (sel == 0) ? cur_clr : 1'b1;
    assign clr_b = (sel == 1) ? cur_clr : 1'b1;
    assign clr_c = (sel == 2) ? cur_clr : 1'b1;

    logic [5:0] ie_a, ie_b, ie_c;
    logic [1:0] ms_a, ms_b, ms_c;
    logic my_a, we_a, r_a, ef_a, bz_a, hl_a, il_a, to_a;
    logic my_b, we_b, r_b, ef_b, bz_b, hl_b, il_b, to_b;
    logic my_c, we_c, r_c, ef_c, bz_c, hl_c, il_c, to_c;

    ctrl_fsm_p #(.OP_W(4), .FETCH_CYCLES(3), .MEM_TIMEOUT(15)) dut_a (
        .clk(clk), .clr(clr_a), .op(cur_op), .mem_ready(cur_rdy),
        .inst_en(ie_a), .mux_sum(ms_a), .mux_y(my_a), .we(we_a), .r(r_a),
        .en_fetch(ef_a), .busy(bz_a), .halted(hl_a), .illegal(il_a), .timeout_err(to_a));

    ctrl_fsm_p #(.OP_W(3), .FETCH_CYCLES(1), .MEM_TIMEOUT(3)) dut_b (
        .clk(clk), .clr(clr_b), .op(cur_op[2:0]), .mem_ready(cur_rdy),
        .inst_en(ie_b), .mux_sum(ms_b), .mux_y(my_b), .we(we_b), .r(r_b),
        .en_fetch(ef_b), .busy(bz_b), .halted(hl_b), .illegal(il_b), .timeout_err(to_b));

    ctrl_fsm_p #(.OP_W(3), .FETCH_CYCLES(5), .MEM_TIMEOUT(15)) dut_c (
        .clk(clk), .clr(clr_c), .op(cur_op[2:0]), .mem_ready(cur_rdy),
        .inst_en(ie_c), .mux_sum(ms_c), .mux_y(my_c), .we(we_c), .r(r_c),
        .en_fetch(ef_c), .busy(bz_c), .halted(hl_c), .illegal(il_c), .timeout_err(to_c));

    // Output bundle {inst_en, mux_sum, mux_y, we, r, en_fetch, busy, halted, illegal, timeout_err}
    logic [15:0] v_a, v_b, v_c, act;
    assign v_a = {ie_a, ms_a, my_a, we_a, r_a, ef_a, bz_a, hl_a, il_a, to_a};
    assign v_b = {ie_b, ms_b, my_b, we_b, r_b, ef_b, bz_b, hl_b, il_b, to_b};
    assign v_c = {ie_c, ms_c, my_c, we_c, r_c, ef_c, bz_c, hl_c, il_c, to_c};
    assign act = (sel == 0) ? v_a : (sel == 1) ? v_b : v_c;

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_now = expq.pop_front();
            n_checks++;
            if (act !== exp_now) begin
                n_errors++;
                $display("FAIL cycle dut=%0d t=%0t got=%b exp=%b", sel, $time, act, exp_now);
            end
        end
    end

    function automatic logic [15:0] vec(input logic [5:0] ie, input logic [1:0] ms,
                                        input logic my, input logic w, input logic rd,
                                        input logic ef, input logic bz, input logic hl);
        return {ie, ms, my, w, rd, ef, bz, hl, m_ill, m_to};
    endfunction

    function automatic logic [15:0] fetch_v(input int k);
        logic [5:0] ie;
        ie = (k == 0) ? 6'b110000 : (k == 1) ? 6'b100001 : (k == 2) ? 6'b100100 : 6'b101000;
        return vec(ie, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic logic [15:0] exec_v(input logic [3:0] o);
        logic [5:0] ie;
        logic [1:0] ms;
        logic my, w, rd;
        ie = 6'b0; ms = 2'b0; my = 1'b0; w = 1'b0; rd = 1'b0;
        if (opw == 3 || !o[3]) begin
            case (o[2:0])
                3'd1: begin ms = 2'b00; my = 1'b1; ie = 6'b000100; end
                3'd2: begin ms = 2'b01; my = 1'b1; ie = 6'b000100; end
                3'd3: begin ms = 2'b10; my = 1'b1; ie = 6'b000100; end
                3'd6: begin ms = 2'b11; my = 1'b1; ie = 6'b000100; end
                3'd4: rd = 1'b1;
                3'd5: w = 1'b1;
                default: ;
            endcase
        end
        return vec(ie, ms, my, w, rd, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic logic [15:0] halt_v();
        return vec(6'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // Drive inputs for the current cycle and queue what it must show
    task automatic step(input logic c, input logic [3:0] o, input logic rdy, input logic [15:0] e);
        cur_clr = c;
        cur_op  = o;
        cur_rdy = rdy;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [15:0] e);
        n_checks++;
        if (act !== e) begin
            n_errors++;
            $display("FAIL %s dut=%0d got=%b exp=%b", nm, sel, act, e);
        end
    endtask

    task automatic instr(input logic [3:0] o, input int nwait);
        logic legal;
        legal = (opw == 3) || !o[3];
        for (int k = 0; k < fc; k++) step(1'b0, 4'($urandom), 1'($urandom), fetch_v(k));
        step(1'b0, o, 1'($urandom), vec(6'b000010, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        step(1'b0, 4'($urandom), 1'($urandom), exec_v(o));
        if (!legal) m_ill = 1'b1;
        if (legal && (o[2:0] == 3'd4 || o[2:0] == 3'd5)) begin
            for (int i = 0; i < to; i++) begin
                step(1'b0, 4'($urandom), (i == nwait),
                     (o[2:0] == 3'd4) ? vec(6'b000100, 2'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)
                                      : vec(6'b000000, 2'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
                if (i == nwait) return;
            end
            m_to = 1'b1;
        end
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), 1'($urandom), halt_v());
    endtask

    task automatic reset_from(input logic [15:0] e_cur);
        step(1'b1, 4'($urandom), 1'($urandom), e_cur);
        m_ill = 1'b0;
        m_to  = 1'b0;
        step(1'b0, 4'($urandom), 1'($urandom), 16'h0000);
    endtask

    task automatic start_dut(input int s, input int f, input int t, input int w);
        sel = s; fc = f; to = t; opw = w;
        m_ill = 1'b0;
        m_to  = 1'b0;
        step(1'b1, 4'($urandom), 1'b0, 16'h0000);
        step(1'b1, 4'($urandom), 1'b0, 16'h0000);
        lit("reset_state", 16'b000000_00_0000_0000);
        step(1'b0, 4'($urandom), 1'b0, 16'h0000);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // OP_W=4, FETCH_CYCLES=3, MEM_TIMEOUT=15
        start_dut(0, 3, 15, 4);
        lit("first_fetch", 16'b110000_00_0001_1000);
        instr(4'b0001, 0);
        lit("add_next_fetch", 16'b110000_00_0001_1000);
        instr(4'b0010, 0);
        instr(4'b0011, 0);
        instr(4'b0110, 0);
        instr(4'b0000, 0);
        instr(4'b0100, 4);
        lit("load_next_fetch", 16'b110000_00_0001_1000);
        instr(4'b0100, 0);
        instr(4'b0101, 2);
        instr(4'b0101, 14);
        lit("store_late_ready", 16'b110000_00_0001_1000);
        instr(4'b1001, 0);
        lit("illegal_set", 16'b110000_00_0001_1010);
        instr(4'b0001, 0);
        instr(4'b1100, 0);
        lit("illegal_sticky", 16'b110000_00_0001_1010);
        reset_from(fetch_v(0));
        lit("illegal_cleared", 16'b110000_00_0001_1000);
        instr(4'b0101, 100);
        lit("timeout_halt", 16'b000000_00_0000_0101);
        halt_hold(4);
        reset_from(halt_v());
        instr(4'b0111, 0);
        lit("halt_op", 16'b000000_00_0000_0100);
        halt_hold(5);
        reset_from(halt_v());
        lit("after_halt_fetch", 16'b110000_00_0001_1000);
        instr(4'b0001, 0);

        // OP_W=3, FETCH_CYCLES=1, MEM_TIMEOUT=3
        start_dut(1, 1, 3, 3);
        instr(4'b0001, 0);
        lit("fc1_fetch", 16'b110000_00_0001_1000);
        instr(4'b0100, 2);
        instr(4'b1001, 0);
        instr(4'b0100, 3);
        lit("fc1_timeout", 16'b000000_00_0000_0101);
        halt_hold(2);
        reset_from(halt_v());
        instr(4'b0111, 0);
        halt_hold(3);
        reset_from(halt_v());
        instr(4'b0010, 0);

        // OP_W=3, FETCH_CYCLES=5, MEM_TIMEOUT=15
        start_dut(2, 5, 15, 3);
        instr(4'b0001, 0);
        instr(4'b0110, 0);
        step(1'b0, 4'($urandom), 1'b0, fetch_v(0));
        step(1'b0, 4'($urandom), 1'b0, fetch_v(1));
        lit("fc5_mid_fetch", 16'b100100_00_0001_1000);
        reset_from(fetch_v(2));
        lit("fc5_after_clr", 16'b110000_00_0001_1000);
        instr(4'b0011, 0);
        instr(4'b0101, 1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
